// File: rtl/ahb_mem_slave_if.sv
// ahb_mem_slave_if: AHB-Lite bus bundle between a master and the memory slave
interface ahb_mem_slave_if #(parameter int DATA_W = 64);
  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hready;
  logic [DATA_W-1:0] hwdata;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;
  modport master (output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
                  input hreadyout, hresp, hrdata);
  modport slave (input hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
                 output hreadyout, hresp, hrdata);
endinterface

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite SRAM model with wait states, ERROR responses, mailbox and write-to-read forwarding
module ahb_mem_slave #(
  parameter int          DATA_W       = 64,
  parameter int          MEM_DEPTH    = 32768,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          WAIT_STATES  = 0,
  parameter logic [31:0] MAILBOX_ADDR = 32'hD058_0000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  ahb_mem_slave_if.slave bus,
  output logic           mailbox_valid_o,
  output logic [7:0]     mailbox_data_o
);
  localparam int LANES = DATA_W / 8;
  localparam int LB = $clog2(LANES);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'(LANES);
  localparam int MB_LANE = int'(MAILBOX_ADDR[LB-1:0]);
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              ready_q, resp_q, pend_q, wr_q, mbx_q, mbv_q;
  logic [AW-1:0]     idx_q, idx_d, rd_idx;
  logic [LANES-1:0]  mask_q, mask_d;
  logic [DATA_W-1:0] rdata_q, rd_word;
  logic [7:0]        mbd_q;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [31:0]       off;
  logic              in_mem, is_mbx, bad, acc, commit, wr_mem, ld_acc, ld_wait, rd_mbx;
  logic              unused_bits;
  assign off = bus.haddr - BASE_ADDR;
  assign in_mem = {1'b0, off} < MEM_BYTES;
  assign is_mbx = bus.haddr == MAILBOX_ADDR;
  assign bad = (bus.hsize > 3'(LB)) || ((bus.haddr & ((32'd1 << bus.hsize) - 32'd1)) != '0) ||
               !(in_mem || is_mbx);
  assign acc = bus.hsel & bus.hready & bus.htrans[1] & ready_q;
  assign idx_d = off[LB +: AW];
  assign mask_d = LANES'(((32'd1 << (32'd1 << bus.hsize)) - 32'd1) << bus.haddr[LB-1:0]);
  assign commit = pend_q & wr_q & ready_q;
  assign wr_mem = commit & ~mbx_q;
  assign ld_acc = acc & ~bad & ~bus.hwrite & (WAIT_STATES == 0);
  assign ld_wait = (state_q == WAIT) & (cnt_q == 4'd1) & ~wr_q;
  assign rd_idx = ld_wait ? idx_q : idx_d;
  assign rd_mbx = ld_wait ? mbx_q : is_mbx;
  assign unused_bits = ^{bus.hburst, bus.hprot, bus.htrans[0], off};
  assign bus.hreadyout = ready_q;
  assign bus.hresp = resp_q;
  assign bus.hrdata = rdata_q;
  assign mailbox_valid_o = mbv_q;
  assign mailbox_data_o = mbd_q;
  // read word, with lanes of a write committing on the same edge forwarded over the stale memory lanes
  always_comb begin
    rd_word = mem[rd_idx];
    for (int l = 0; l < LANES; l++)
      if (wr_mem && idx_q == rd_idx && mask_q[l]) rd_word[8*l +: 8] = bus.hwdata[8*l +: 8];
  end
  // byte-masked memory write at the end of an OKAY write data phase
  always_ff @(posedge clk_i)
    if (wr_mem)
      for (int l = 0; l < LANES; l++)
        if (mask_q[l]) mem[idx_q][8*l +: 8] <= bus.hwdata[8*l +: 8];
  // response FSM, address-phase capture, read data and mailbox pulse
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      mbx_q   <= 1'b0;
      idx_q   <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      mbv_q   <= 1'b0;
      mbd_q   <= '0;
    end else begin
      mbv_q <= commit & mbx_q;
      if (commit & mbx_q) mbd_q <= bus.hwdata[8*MB_LANE +: 8];
      if (ld_acc | ld_wait) rdata_q <= rd_mbx ? '0 : rd_word;
      else if (acc & bad & ~bus.hwrite) rdata_q <= '0;
      if (ready_q) pend_q <= acc & ~bad;
      if (acc) begin
        wr_q   <= bus.hwrite;
        mbx_q  <= is_mbx;
        idx_q  <= idx_d;
        mask_q <= mask_d;
      end
      case (state_q)
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        ERR1: begin
          state_q <= ERR2;
          ready_q <= 1'b1;
        end
        default:
          if (acc & bad) begin
            state_q <= ERR1;
            ready_q <= 1'b0;
            resp_q  <= 1'b1;
          end else if (acc && WAIT_STATES != 0) begin
            state_q <= WAIT;
            cnt_q   <= 4'(WAIT_STATES);
            ready_q <= 1'b0;
            resp_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
          end
      endcase
    end
endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: randomized AHB-Lite traffic on two slaves (0 and 3 wait states) against a byte-level memory model
module tb_ahb_mem_slave;
  localparam int DEPTH = 1024;
  localparam logic [31:0] MBX = 32'hD058_0000;
  typedef struct packed {logic v; logic [31:0] a; logic w; logic [2:0] sz; logic [63:0] d;} xfer_t;
  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic hsel = 1'b0, hwrite = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0] htrans = '0;
  logic [2:0] hsize = '0;
  logic [63:0] hwdata = '0;
  logic rdy, resp, mv, mv0, mv3;
  logic [63:0] rdata;
  logic [7:0] md, md0, md3;
  int checks = 0, errors = 0, waits = 0;
  bit mb_exp = 1'b0;
  logic [7:0] mb_dexp = '0;
  logic [63:0] last_rd = '0;
  xfer_t q[$];
  xfer_t ap = '0, dp = '0;
  bit [7:0] mm [longint];
  always #5 clk = ~clk;
  ahb_mem_slave_if #(.DATA_W(64)) b0 ();
  ahb_mem_slave_if #(.DATA_W(64)) b3 ();
  assign b0.hsel = hsel & ~sel;
  assign b3.hsel = hsel & sel;
  assign b0.haddr = haddr;
  assign b3.haddr = haddr;
  assign b0.htrans = htrans;
  assign b3.htrans = htrans;
  assign b0.hwrite = hwrite;
  assign b3.hwrite = hwrite;
  assign b0.hsize = hsize;
  assign b3.hsize = hsize;
  assign b0.hburst = 3'd0;
  assign b3.hburst = 3'd1;
  assign b0.hprot = 4'd3;
  assign b3.hprot = 4'd0;
  assign b0.hwdata = hwdata;
  assign b3.hwdata = hwdata;
  assign rdy = sel ? b3.hreadyout : b0.hreadyout;
  assign b0.hready = rdy;
  assign b3.hready = rdy;
  assign resp = sel ? b3.hresp : b0.hresp;
  assign rdata = sel ? b3.hrdata : b0.hrdata;
  assign mv = sel ? mv3 : mv0;
  assign md = sel ? md3 : md0;
  ahb_mem_slave #(.DATA_W(64), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b0.slave), .mailbox_valid_o(mv0), .mailbox_data_o(md0));
  ahb_mem_slave #(.DATA_W(64), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b3.slave), .mailbox_valid_o(mv3), .mailbox_data_o(md3));
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic longint key(logic [31:0] a);
    return {31'd0, sel, a};
  endfunction
  function automatic bit illegal(logic [31:0] a, logic [2:0] sz);
    return sz > 3'd3 || a % (32'd1 << sz) != 0 || (a >= 32'(DEPTH * 8) && a != MBX);
  endfunction
  function automatic logic [63:0] exp_word(logic [31:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mm[key((a & ~32'd7) + 32'(i))];
    return w;
  endfunction
  task automatic commit(xfer_t x);
    if (x.a == MBX) begin
      mb_exp = 1'b1;
      mb_dexp = x.d[8*(MBX % 8) +: 8];
    end else
      for (int i = 0; i < (1 << x.sz); i++) begin
        automatic int l = int'(x.a % 8) + i;
        mm[key((x.a & ~32'd7) + 32'(l))] = x.d[8*l +: 8];
      end
  endtask
  task automatic push(logic [31:0] a, logic w, logic [2:0] sz, logic [63:0] d);
    xfer_t x;
    x.v = 1'b1;
    x.a = a;
    x.w = w;
    x.sz = sz;
    x.d = d;
    q.push_back(x);
  endtask
  task automatic push_rand();
    int k;
    logic [31:0] a;
    logic [2:0] sz;
    if ($urandom_range(0, 3) == 0) q.push_back('0);
    k = $urandom_range(0, 9);
    sz = 3'($urandom_range(0, 3));
    a = 32'h0 + 32'(8 * $urandom_range(0, 47)) + (32'($urandom_range(0, 7)) & ~((32'd1 << sz) - 32'd1));
    if (k == 6) begin
      sz = 3'($urandom_range(1, 3));
      a = (a & ~32'd7) + 32'd1;
    end else if (k == 7) a = 32'h2000 + 32'(8 * $urandom_range(0, 100));
    else if (k == 8) begin
      a = MBX;
      sz = 3'd0;
    end else if (k == 9) sz = 3'($urandom_range(4, 7));
    push(a, 1'($urandom_range(0, 1)), sz, {$urandom, $urandom});
  endtask
  task automatic drive();
    haddr = ap.a;
    hwrite = ap.w;
    hsize = ap.sz;
    hsel = ap.v;
    htrans = ap.v ? {1'b1, 1'($urandom_range(0, 1))} : {1'b0, 1'($urandom_range(0, 1))};
    hwdata = (dp.v && dp.w) ? dp.d : {$urandom, $urandom};
  endtask
  task automatic cycle();
    bit r, bad;
    @(negedge clk);
    r = rdy;
    chk("mbx_valid", 64'(mv), 64'(mb_exp));
    if (mb_exp) chk("mbx_data", 64'(md), 64'(mb_dexp));
    mb_exp = 1'b0;
    if (dp.v) begin
      bad = illegal(dp.a, dp.sz);
      if (!r) begin
        waits++;
        chk("resp_stall", 64'(resp), 64'(bad));
        if (waits > 20) begin
          errors++;
          $display("FAIL data_phase_timeout addr=%h got=stalled exp=complete", dp.a);
          $fatal(1, "data phase never completed");
        end
      end else begin
        chk("wait_cycles", 64'(waits), 64'(bad ? 1 : (sel ? 3 : 0)));
        chk("resp", 64'(resp), 64'(bad));
        if (!dp.w) begin
          chk("rdata", rdata, (bad || dp.a == MBX) ? 64'd0 : exp_word(dp.a));
          last_rd = rdata;
        end
        if (dp.w && !bad) commit(dp);
        waits = 0;
      end
    end else chk("idle_ready", 64'(rdy), 64'd1);
    @(posedge clk);
    #1;
    if (r) begin
      dp = ap;
      ap = q.size() != 0 ? q.pop_front() : '0;
      drive();
    end
  endtask
  task automatic run();
    int n = 0;
    while (q.size() != 0 || ap.v || dp.v) begin
      cycle();
      n++;
      if (n > 5000) begin
        errors++;
        $display("FAIL run_timeout got=%0d cycles exp=<5000", n);
        $fatal(1, "run did not drain");
      end
    end
    cycle();
  endtask
  task automatic preload();
    for (int i = 0; i < 48; i++) push(32'(8 * i), 1'b1, 3'd3, {$urandom, $urandom} | 64'd1);
    run();
  endtask
  initial begin
    @(negedge clk);
    chk("rst_ready0", 64'(b0.hreadyout), 64'd1);
    chk("rst_resp0", 64'(b0.hresp), 64'd0);
    chk("rst_rdata0", b0.hrdata, 64'd0);
    chk("rst_mbv0", 64'(mv0), 64'd0);
    chk("rst_ready3", 64'(b3.hreadyout), 64'd1);
    chk("rst_resp3", 64'(b3.hresp), 64'd0);
    chk("rst_rdata3", b3.hrdata, 64'd0);
    chk("rst_mbd3", 64'(md3), 64'd0);
    rst_n = 1'b1;
    preload();
    push(32'h100, 1'b1, 3'd3, 64'h1122_3344_5566_7788);
    push(32'h100, 1'b0, 3'd3, 64'd0);
    run();
    chk("fwd_read", last_rd, 64'h1122_3344_5566_7788);
    push(32'h100, 1'b1, 3'd3, 64'd0);
    push(32'h103, 1'b1, 3'd0, 64'h0000_0000_AB00_0000);
    push(32'h100, 1'b0, 3'd3, 64'd0);
    run();
    chk("byte_write", last_rd, 64'h0000_0000_AB00_0000);
    push(32'h101, 1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    push(32'h100, 1'b0, 3'd3, 64'd0);
    run();
    chk("misaligned_nochg", last_rd, 64'h0000_0000_AB00_0000);
    push(32'h2000, 1'b0, 3'd3, 64'd0);
    push(32'h100, 1'b0, 3'd3, 64'd0);
    run();
    chk("after_range_err", last_rd, 64'h0000_0000_AB00_0000);
    push(MBX, 1'b1, 3'd0, 64'h2A);
    push(MBX, 1'b0, 3'd3, 64'd0);
    push(32'h0, 1'b0, 3'd3, 64'd0);
    run();
    chk("mbx_word0_kept", last_rd, exp_word(32'h0));
    for (int i = 0; i < 300; i++) push_rand();
    run();
    sel = 1'b1;
    preload();
    push(32'h100, 1'b0, 3'd3, 64'd0);
    run();
    for (int i = 0; i < 150; i++) push_rand();
    run();
    push(32'h100, 1'b1, 3'd3, 64'h0123_4567_89AB_CDEF);
    push(32'h100, 1'b0, 3'd3, 64'd0);
    run();
    chk("ws3_read", last_rd, 64'h0123_4567_89AB_CDEF);
    @(posedge clk);
    #1;
    haddr = 32'h108;
    hwrite = 1'b1;
    hsize = 3'd3;
    htrans = 2'b10;
    hsel = 1'b1;
    @(posedge clk);
    #1;
    hsel = 1'b0;
    htrans = 2'b00;
    hwdata = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk);
    chk("pre_rst_wait", 64'(rdy), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(rdy), 64'd1);
    chk("mid_rst_resp", 64'(resp), 64'd0);
    chk("mid_rst_rdata", rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ap = '0;
    dp = '0;
    waits = 0;
    mb_exp = 1'b0;
    push(32'h108, 1'b0, 3'd3, 64'd0);
    run();
    chk("dropped_write", last_rd, exp_word(32'h108));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_mem_slave.md
# ahb_mem_slave

Parametrised AHB-Lite slave memory model for the testbench: byte-addressable SRAM of configurable data width and depth, programmable wait states, and AHB-Lite two-cycle ERROR responses for illegal transfers. Sits on the core's AHB-Lite ports (instruction, LSU or DMA side) in place of a real memory. Decodes a mailbox address that the bench monitors for test pass/fail and console output. Correctly forwards write data into a back-to-back read, so pipelined write→read sequences observe the new data.

## Interface
- DATA_W, 64: HWDATA/HRDATA width; 32 or 64 only.
- MEM_DEPTH, 32768: number of DATA_W-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to MEM_DEPTH*DATA_W/8.
- WAIT_STATES, 0: extra HREADYOUT-low cycles per accepted NONSEQ/SEQ transfer; 0..15.
- MAILBOX_ADDR, 32'hD058_0000: write-only mailbox byte address; outside the memory range.
- HCLK  in  1  clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, 2^HSIZE bytes.
- HBURST, HPROT  in  3, 4  accepted and ignored.
- HREADY  in  1  bus ready (address phase qualifier).
- HWDATA  in  DATA_W  write data, valid in data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_W  read data.
- mailbox_valid  out  1  one-cycle pulse on a completed mailbox write.
- mailbox_data  out  8  byte written to the mailbox, i.e. HWDATA lane at MAILBOX_ADDR.

## Operation
- Accept: HSEL & HREADY & HTRANS[1] at a rising edge. Register addr, write, size and byte mask. IDLE/BUSY, or not selected: no action, OKAY.
- Byte mask: (2^HSIZE)-bit run starting at lane HADDR[log2(DATA_W/8)-1:0].
- Illegal transfer → ERROR. Cases:
  - HSIZE > log2(DATA_W/8);
  - HADDR not aligned to 2^HSIZE;
  - address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*DATA_W/8) and not MAILBOX_ADDR.
- ERROR transfers never modify memory.
- States: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
  - Legal accept with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES. WAIT holds HREADYOUT=0 and decrements; at count 1 → IDLE, so the final cycle has HREADYOUT=1.
  - Illegal accept → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE. An accept in ERR2 is processed normally.
- Write commit: at the edge ending the data phase (HREADYOUT=1, OKAY), mem[idx] lanes under mask ← HWDATA lanes. Unmasked lanes are unchanged.
  - Mailbox target: memory is not written; mailbox_valid=1 for the next cycle with mailbox_data = the addressed byte.
- Read: HRDATA is loaded at the edge that ends the data phase's final cycle-1 (i.e. on accept when WAIT_STATES=0, else at WAIT count 1) with the full word mem[idx]; all lanes are driven.
- Forwarding: if that load coincides with the commit of a pending write to the same idx, masked lanes take HWDATA.
- HRDATA holds its value between reads. Reads of the mailbox, and ERROR reads, return 0.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, mailbox_valid=0, mailbox_data=0, state IDLE, counter 0. Memory contents are not reset.
- Legal transfer: data phase is 1+WAIT_STATES cycles. The address phase of the next transfer overlaps the final data-phase cycle.
- ERROR: always exactly 2 cycles, independent of WAIT_STATES.
- Reset asserted mid-transfer: outputs go to reset values immediately. A pending write is dropped.
- Back-to-back NONSEQ/SEQ transfers at WAIT_STATES=0 sustain one transfer per cycle.

## Test plan
- WAIT_STATES=0, DATA_W=64: write 64'h1122_3344_5566_7788 to 0x100, then immediately read 0x100 (pipelined) → HRDATA=64'h1122_3344_5566_7788 one cycle after the read accept (forwarding).
- Byte write 8'hAB to 0x103 after a full-word write of 0 → read 0x100 returns 64'h0000_0000_AB00_0000; halfword write to 0x101 → ERROR (misaligned), memory unchanged.
- WAIT_STATES=3: single read → HREADYOUT low for exactly 3 cycles, then high with valid data.
- Read address BASE_ADDR+MEM_DEPTH*8 → HRESP=1 with HREADYOUT 0 then 1; next transfer is OKAY.
- Write 8'h2A to MAILBOX_ADDR → mailbox_valid pulses for 1 cycle with mailbox_data=8'h2A; memory is not modified.
- Assert HRESETn low during WAIT → HREADYOUT=1, HRESP=0, HRDATA=0 asynchronously; the dropped write is not visible on a later read.
